// File: rtl/johnson_step_ctrl_pkg.sv
// rtl/johnson_step_ctrl_pkg.sv - shared FSM state and direction encodings for the Johnson step sequencer
package johnson_step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/johnson_step_ctrl_if.sv
// rtl/johnson_step_ctrl_if.sv - step command valid/ready channel
interface johnson_step_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_div;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  cmd_div,
        output cmd_ready
    );

endinterface

// File: rtl/johnson_step_ctrl_shift.sv
// rtl/johnson_step_ctrl_shift.sv - bidirectional Johnson phase register with legality decode
module johnson_shift
    import johnson_step_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_en,
    input  logic         dir,
    input  logic         clr,
    output logic [W-1:0] phase,
    output logic         legal
);

    int unsigned n_edges;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (step_en) begin
            if (dir == DIR_FWD) begin
                phase <= {~phase[0], phase[W-1:1]};
            end else begin
                phase <= {phase[W-2:0], ~phase[W-1]};
            end
        end
    end

    // A legal Johnson code has at most one 0/1 boundary between adjacent stages.
    always_comb begin
        n_edges = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (phase[i] != phase[i+1]) begin
                n_edges = n_edges + 1;
            end
        end
        legal = (n_edges <= 1);
    end

endmodule

// File: rtl/johnson_step_ctrl.sv
// rtl/johnson_step_ctrl.sv - command-driven Johnson phase sequencer: FSM, step divider, step counter, flags
module johnson_step_ctrl
    import johnson_step_ctrl_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_step_ctrl_if.slave    cmd,
    input  logic                  abort,
    output logic [W-1:0]          phase,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  err,
    output logic [CNT_W-1:0]      steps_left
);

    state_t           state;
    logic             dir_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] divcnt;
    logic             accept;
    logic             step_en;
    logic             legal;

    assign cmd.cmd_ready = (state == IDLE) && rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // An illegal code is cleared first; the pending step is retried on a following edge.
    assign step_en = (state == RUN) && !abort && (divcnt == '0) && legal;

    johnson_shift #(
        .W (W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .dir     (dir_q),
        .clr     (~legal),
        .phase   (phase),
        .legal   (legal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            steps_left <= '0;
            dir_q      <= DIR_FWD;
            div_q      <= '0;
            divcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dir_q      <= cmd.cmd_dir;
                        div_q      <= cmd.cmd_div;
                        divcnt     <= cmd.cmd_div;
                        steps_left <= cmd.cmd_steps;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        if (cmd.cmd_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (divcnt != '0) begin
                        divcnt <= divcnt - DIV_W'(1);
                    end else if (legal) begin
                        steps_left <= steps_left - CNT_W'(1);
                        divcnt     <= div_q;
                        if (steps_left == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
            // Written last so a corrupt code seen on the accepting edge still latches err.
            if (!legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule
